// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch program-counter stage.
// Holds the fetch state encoding, the default vectors and the INC alignment-mask helper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

    // Low-order bits that must be zero for an INC-aligned address (INC is a power of two).
    function automatic logic [31:0] inc_align_mask(input int unsigned inc);
        return 32'(inc - 1);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_redirect_buffer.sv
// Holds one branch/jump target that arrived while the pipeline was frozen.
// A newer load overwrites the stored target; clear wins over load.
module pc_redirect_buffer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_target,
    output logic              pending,
    output logic [ADDR_W-1:0] target
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            target  <= '0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b1;
            target  <= load_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch program counter: exception > redirect > buffered redirect > increment > hold,
// with post-redirect squash bubbles and an instruction-memory handshake.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// ST_START  | first cycle after reset release, no fetch issued yet
// ST_RUN    | pc_out is a live fetch request
// ST_BUBBLE | squashing fetches after a redirect, bub_cnt counts down to RUN
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR),
    parameter int unsigned       INC          = 4,
    parameter int unsigned       BUBBLE       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_freeze,
    input  logic              exc_valid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              fetch_valid,
    output logic              redirect_pending,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(inc_align_mask(INC));
    localparam logic [ADDR_W-1:0] INC_W      = ADDR_W'(INC);
    localparam logic [2:0]        BUBBLE_W   = 3'(BUBBLE);

    fetch_state_t      state;
    logic [2:0]        bub_cnt;
    logic [ADDR_W-1:0] pend_target;

    logic              active;
    logic              adv;
    logic              take_redirect;
    logic              take_pending;
    logic              do_jump;
    logic [ADDR_W-1:0] jump_target;
    logic              jump_misaligned;
    logic              apply;
    logic [ADDR_W-1:0] apply_pc;
    logic              buf_load;
    logic              buf_clear;

    assign pc_plus_inc = pc_out + INC_W;

    always_comb begin
        active          = (state != ST_START);
        adv             = fetch_valid & fetch_ready & ~pc_freeze;
        take_redirect   = redirect_valid & ~pc_freeze;
        take_pending    = ~redirect_valid & redirect_pending & ~pc_freeze;
        do_jump         = active & ~exc_valid & (take_redirect | take_pending);
        jump_target     = take_redirect ? redirect_target : pend_target;
        jump_misaligned = (INC > 1) && ((jump_target & ALIGN_MASK) != '0);
        apply           = active & (exc_valid | do_jump);
        // A misaligned target is steered to the exception vector.
        apply_pc        = (exc_valid | jump_misaligned) ? EXC_VECTOR : jump_target;
        buf_load        = active & ~exc_valid & redirect_valid & pc_freeze;
        buf_clear       = apply;
    end

    pc_redirect_buffer #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buffer (
        .clk         (clk),
        .reset       (reset),
        .load        (buf_load),
        .clear       (buf_clear),
        .load_target (redirect_target),
        .pending     (redirect_pending),
        .target      (pend_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_START;
            pc_out       <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
            bub_cnt      <= '0;
        end else begin
            misalign_err <= do_jump & jump_misaligned;
            if (state == ST_START) begin
                state       <= ST_RUN;
                fetch_valid <= 1'b1;
            end else if (apply) begin
                pc_out <= apply_pc;
                if (BUBBLE == 0) begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                    bub_cnt     <= '0;
                end else begin
                    state       <= ST_BUBBLE;
                    fetch_valid <= 1'b0;
                    bub_cnt     <= BUBBLE_W;
                end
            end else begin
                if (adv) begin
                    pc_out <= pc_out + INC_W;
                end
                if (state == ST_BUBBLE) begin
                    if (bub_cnt <= 3'd1) begin
                        state       <= ST_RUN;
                        fetch_valid <= 1'b1;
                        bub_cnt     <= '0;
                    end else begin
                        bub_cnt <= bub_cnt - 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against a behavioural next-PC model.
module tb_pc_fetch_unit;

    localparam int unsigned INC_P    = 4;
    localparam int unsigned BUBBLE_P = 1;
    localparam logic [31:0] EXC_V    = 32'h0000_0080;
    localparam logic [31:0] RST_V    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_freeze;
    logic        exc_valid;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_inc;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_fv;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_merr;
    logic        m_started;
    int          m_bub;

    pc_fetch_unit #(
        .ADDR_W       (32),
        .RESET_VECTOR (RST_V),
        .EXC_VECTOR   (EXC_V),
        .INC          (INC_P),
        .BUBBLE       (BUBBLE_P)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_freeze        (pc_freeze),
        .exc_valid        (exc_valid),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .fetch_ready      (fetch_ready),
        .pc_out           (pc_out),
        .pc_plus_inc      (pc_plus_inc),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RST_V;
        m_fv      = 1'b0;
        m_pend    = 1'b0;
        m_ptgt    = '0;
        m_merr    = 1'b0;
        m_started = 1'b0;
        m_bub     = 0;
    endtask

    // One clock of the reference: priority list applied to the inputs present at the edge.
    task automatic model_clock();
        logic        jumped;
        logic [31:0] jt;
        jumped = 1'b0;
        jt     = '0;
        m_merr = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
            m_fv      = 1'b1;
            return;
        end
        if (exc_valid) begin
            jt = EXC_V; jumped = 1'b1;
        end else if (redirect_valid && !pc_freeze) begin
            jt = redirect_target; jumped = 1'b1;
        end else if (redirect_valid && pc_freeze) begin
            m_pend = 1'b1; m_ptgt = redirect_target;
        end else if (m_pend && !pc_freeze) begin
            jt = m_ptgt; jumped = 1'b1;
        end else if (m_fv && fetch_ready && !pc_freeze) begin
            m_pc = m_pc + INC_P;
        end
        if (jumped) begin
            if (jt % INC_P != 0) begin
                jt     = EXC_V;
                m_merr = 1'b1;
            end
            m_pc   = jt;
            m_pend = 1'b0;
            m_bub  = BUBBLE_P;
            m_fv   = (BUBBLE_P == 0);
        end else if (m_bub > 0) begin
            m_bub--;
            if (m_bub == 0) m_fv = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("pc_out", pc_out, m_pc);
        check("pc_plus_inc", pc_plus_inc, m_pc + INC_P);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        check("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_merr});
    endtask

    task automatic step(input logic frz, input logic exc, input logic rv,
                        input logic [31:0] tgt, input logic rdy);
        pc_freeze       = frz;
        exc_valid       = exc;
        redirect_valid  = rv;
        redirect_target = tgt;
        fetch_ready     = rdy;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] rt;
        reset = 1'b0;
        pc_freeze = 1'b0; exc_valid = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; fetch_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        #2;
        check("start_fv", {31'b0, fetch_valid}, 32'd0);

        // Start-up and sequential fetch 0,4,8,...
        step(0, 0, 0, 0, 1);
        check("run_pc0", pc_out, 32'h0);
        check("run_fv", {31'b0, fetch_valid}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("seq_pc4", pc_out, 32'h4);
        repeat (3) step(0, 0, 0, 0, 1);
        check("seq_pc10", pc_out, 32'h10);

        // Redirect with one bubble
        step(0, 0, 1, 32'h200, 1);
        check("redir_pc", pc_out, 32'h200);
        check("redir_bubble", {31'b0, fetch_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("redir_fv_back", {31'b0, fetch_valid}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("redir_seq", pc_out, 32'h204);

        // Redirect under freeze, newer target wins
        held_pc = pc_out;
        step(1, 0, 1, 32'h300, 1);
        step(1, 0, 1, 32'h400, 1);
        step(1, 0, 0, 0, 1);
        check("frz_hold", pc_out, held_pc);
        check("frz_pending", {31'b0, redirect_pending}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("frz_release_pc", pc_out, 32'h400);
        check("frz_release_pend", {31'b0, redirect_pending}, 32'd0);
        repeat (2) step(0, 0, 0, 0, 1);

        // Exception beats a redirect while frozen and clears the pending target
        step(1, 0, 1, 32'h500, 1);
        step(1, 1, 1, 32'h600, 1);
        check("exc_pc", pc_out, EXC_V);
        check("exc_pend_clr", {31'b0, redirect_pending}, 32'd0);
        repeat (2) step(0, 0, 0, 0, 1);

        // Misaligned redirect
        step(0, 0, 1, 32'h202, 1);
        check("mis_pc", pc_out, EXC_V);
        check("mis_pulse", {31'b0, misalign_err}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("mis_pulse_end", {31'b0, misalign_err}, 32'd0);
        step(0, 0, 0, 0, 1);

        // Wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_pc", pc_out, 32'h0);

        // Memory back-pressure
        held_pc = pc_out;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("bp_hold", pc_out, held_pc);
        check("bp_fv", {31'b0, fetch_valid}, 32'd1);

        // Async reset in the middle of a bubble
        step(0, 0, 1, 32'h1000, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_pc", pc_out, RST_V);
        check("arst_fv", {31'b0, fetch_valid}, 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 7) != 0) rt = rt & ~32'h3;
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0,
                 rt,
                 $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
